// File: rtl/life_step_scheduler.sv
// Sequences one generation of a 1-D Wolfram automaton over a line memory, alternating write
// and read slots and yielding the memory port to the display whenever displayActive is high.
module life_step_scheduler #(
    parameter int CELLS = 640,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          displayActive,
    input  logic          frameStart,
    input  logic          stepRequest,
    input  logic [7:0]    rule,
    input  logic [2:0]    aliveColor,
    output logic [AW-1:0] memAddr,
    output logic          memWe,
    output logic [3:0]    memWdata,
    input  logic [3:0]    memRdata,
    output logic          busy,
    output logic          stepDone,
    output logic [15:0]   generation
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        PRIME = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0] PENULT    = AW'(CELLS - 2);
    localparam logic          PH_W      = 1'b0;
    localparam logic          PH_R      = 1'b1;

    state_t        r_state;
    logic          r_pending;
    logic          r_busy;
    logic          r_step_done;
    logic [15:0]   r_gen;
    logic [7:0]    r_rule;
    logic          r_left;
    logic          r_center;
    logic          r_right;
    logic          r_cell0;
    logic [AW-1:0] r_i;
    logic          r_phase;
    logic [1:0]    r_prime_cnt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [3:0]    r_wdata;

    logic          w_rd_alive;
    logic          w_pend_req;
    logic          w_shift_in;

    function automatic logic is_alive(input logic [3:0] v);
        return (v & 4'b0111) != 4'b0000;
    endfunction

    function automatic logic [3:0] cell_next(input logic [7:0] r, input logic l, input logic c,
                                             input logic rt, input logic [2:0] col);
        return r[{l, c, rt}] ? {1'b0, col} : 4'b0000;
    endfunction

    assign w_rd_alive = is_alive(memRdata);
    assign w_pend_req = r_pending | stepRequest;
    // The neighbour past the last cell is cell 0 as it was before this pass overwrote it.
    assign w_shift_in = (r_i == PENULT) ? r_cell0 : w_rd_alive;

    // The write strobe is cut combinationally so the display never sees our write, even in
    // the cycle where it takes the port back.
    assign memWe      = r_we & ~displayActive;
    assign memAddr    = r_addr;
    assign memWdata   = r_wdata;
    assign busy       = r_busy;
    assign stepDone   = r_step_done;
    assign generation = r_gen;

    // Pass sequencer: request/arm handshake, prime reads, write/read slots, completion.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_busy      <= 1'b0;
            r_step_done <= 1'b0;
            r_gen       <= 16'd0;
            r_rule      <= 8'd0;
            r_left      <= 1'b0;
            r_center    <= 1'b0;
            r_right     <= 1'b0;
            r_cell0     <= 1'b0;
            r_i         <= '0;
            r_phase     <= PH_W;
            r_prime_cnt <= 2'd0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= 4'b0000;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pending <= w_pend_req;
                    if (w_pend_req) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (frameStart && !displayActive) begin
                        r_rule      <= rule;
                        r_pending   <= stepRequest;
                        r_busy      <= 1'b1;
                        r_prime_cnt <= 2'd0;
                        r_addr      <= LAST_CELL;
                        r_we        <= 1'b0;
                        r_wdata     <= 4'b0000;
                        r_state     <= PRIME;
                    end else begin
                        r_pending <= 1'b1;
                    end
                end
                PRIME: begin
                    r_pending <= w_pend_req;
                    // A stalled cycle captures nothing; the held address re-issues the read.
                    if (!displayActive) begin
                        case (r_prime_cnt)
                            2'd0: begin
                                r_left      <= w_rd_alive;
                                r_addr      <= '0;
                                r_prime_cnt <= 2'd1;
                            end
                            2'd1: begin
                                r_center    <= w_rd_alive;
                                r_cell0     <= w_rd_alive;
                                r_addr      <= AW'(1);
                                r_prime_cnt <= 2'd2;
                            end
                            default: begin
                                r_right     <= w_rd_alive;
                                r_i         <= '0;
                                r_phase     <= PH_W;
                                r_addr      <= '0;
                                r_we        <= 1'b1;
                                r_wdata     <= cell_next(r_rule, r_left, r_center, w_rd_alive,
                                                         aliveColor);
                                r_prime_cnt <= 2'd0;
                                r_state     <= RUN;
                            end
                        endcase
                    end
                end
                RUN: begin
                    r_pending <= w_pend_req;
                    if (!displayActive) begin
                        if (r_phase == PH_W) begin
                            r_we    <= 1'b0;
                            r_wdata <= 4'b0000;
                            if (r_i == LAST_CELL) begin
                                r_addr      <= '0;
                                r_busy      <= 1'b0;
                                r_step_done <= 1'b1;
                                r_gen       <= r_gen + 16'd1;
                                r_state     <= DONE;
                            end else begin
                                r_phase <= PH_R;
                                r_addr  <= (r_i == PENULT) ? '0 : r_i + AW'(2);
                            end
                        end else begin
                            r_left   <= r_center;
                            r_center <= r_right;
                            r_right  <= w_shift_in;
                            r_i      <= r_i + AW'(1);
                            r_phase  <= PH_W;
                            r_addr   <= r_i + AW'(1);
                            r_we     <= 1'b1;
                            r_wdata  <= cell_next(r_rule, r_center, r_right, w_shift_in,
                                                  aliveColor);
                        end
                    end
                end
                DONE: begin
                    r_pending <= w_pend_req;
                    r_state   <= w_pend_req ? ARM : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_addr  <= '0;
                    r_we    <= 1'b0;
                    r_wdata <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_step_scheduler.sv
// Randomised bench: line memory with display contention, compared with an array model of the rule.
module tb_life_step_scheduler;

    localparam int CELLS = 640;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          displayActive;
    logic          frameStart;
    logic          stepRequest;
    logic [7:0]    rule;
    logic [2:0]    aliveColor;
    logic [AW-1:0] memAddr;
    logic          memWe;
    logic [3:0]    memWdata;
    logic [3:0]    memRdata;
    logic          busy;
    logic          stepDone;
    logic [15:0]   generation;

    int n_vec = 0;
    int n_err = 0;
    int we_viol = 0;

    logic [3:0] mem  [CELLS];
    logic [3:0] img  [CELLS];
    logic [3:0] expv [CELLS];
    logic       load_req = 1'b0;

    life_step_scheduler #(.CELLS(CELLS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .displayActive(displayActive), .frameStart(frameStart),
        .stepRequest(stepRequest), .rule(rule), .aliveColor(aliveColor), .memAddr(memAddr),
        .memWe(memWe), .memWdata(memWdata), .memRdata(memRdata), .busy(busy),
        .stepDone(stepDone), .generation(generation)
    );

    always #5 clk = ~clk;

    // Line memory; while the display owns the port it reads junk and must see no write.
    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < CELLS; k++) mem[k] <= img[k];
        end else if (displayActive) begin
            if (memWe) we_viol <= we_viol + 1;
            memRdata <= 4'($urandom);
        end else begin
            if (memWe) mem[memAddr] <= memWdata;
            memRdata <= mem[memAddr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int alive(input logic [3:0] v);
        return ((v % 8) != 0) ? 1 : 0;
    endfunction

    task automatic ref_step(input logic [7:0] r, input logic [2:0] col);
        logic [3:0] nxt [CELLS];
        logic [7:0] rv;
        int idx;
        rv = r;
        for (int k = 0; k < CELLS; k++) begin
            idx = 4 * alive(expv[(k + CELLS - 1) % CELLS]) + 2 * alive(expv[k])
                + alive(expv[(k + 1) % CELLS]);
            nxt[k] = rv[idx] ? {1'b0, col} : 4'd0;
        end
        for (int k = 0; k < CELLS; k++) expv[k] = nxt[k];
    endtask

    // mode 0: random image, otherwise a single live cell at position `pos`
    task automatic load_image(input int mode, input int pos);
        for (int k = 0; k < CELLS; k++) begin
            img[k] = (mode == 0) ? 4'($urandom) : 4'd0;
        end
        if (mode != 0) img[pos] = 4'b0011;
        for (int k = 0; k < CELLS; k++) expv[k] = img[k];
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
        tick();
    endtask

    task automatic compare_mem(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < CELLS; k++) if (mem[k] !== expv[k]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic run_pass(input bit do_req, input bit stall, input int extra_req,
                            output int busy_cyc, output int dones);
        logic [7:0] r0;
        int c;
        r0 = rule;
        c = 0;
        busy_cyc = 0;
        dones = 0;
        if (do_req) begin
            stepRequest = 1'b1;
            tick();
            stepRequest = 1'b0;
        end
        tick();
        displayActive = 1'b0;
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        while (c < 6000) begin
            if (busy) busy_cyc++;
            if (stepDone) begin
                dones++;
                break;
            end
            displayActive = stall && ((c % 20) >= 13);
            stepRequest = (extra_req >= 1 && c == 50) || (extra_req >= 2 && c == 60);
            if (c == 100) rule = ~r0;
            tick();
            c++;
        end
        check("pass_within_budget", (c < 6000) ? 1 : 0, 1);
        displayActive = 1'b0;
        stepRequest = 1'b0;
        rule = r0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (stepDone) dones++;
        end
    endtask

    initial begin
        int bc;
        int dn;
        int extra_done;
        logic [3:0] old [CELLS];

        rst = 1'b1;
        displayActive = 1'b0;
        frameStart = 1'b0;
        stepRequest = 1'b0;
        rule = 8'h5A;
        aliveColor = 3'b101;
        #1;
        check("rst_busy", busy, 0);
        check("rst_stepDone", stepDone, 0);
        check("rst_memWe", memWe, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_memWdata", memWdata, 0);
        check("rst_generation", generation, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tick();
        check("frame_in_idle_ignored", busy, 0);

        // single centre cell under rule 90, rule flipped mid-pass
        load_image(1, 320);
        run_pass(1'b1, 1'b0, 0, bc, dn);
        ref_step(8'h5A, aliveColor);
        check("pass_cycles", bc, 1282);
        check("center_done_pulses", dn, 1);
        check("center_generation", generation, 1);
        check("cell319", mem[319], 4'b0101);
        check("cell321", mem[321], 4'b0101);
        check("cell320", mem[320], 4'b0000);
        compare_mem("center_mem");

        load_image(1, 0);
        run_pass(1'b1, 1'b0, 0, bc, dn);
        ref_step(8'h5A, aliveColor);
        check("wrap0_cell639", mem[639], 4'b0101);
        check("wrap0_cell1", mem[1], 4'b0101);
        check("wrap0_cell0", mem[0], 4'b0000);
        compare_mem("wrap0_mem");

        load_image(1, 639);
        run_pass(1'b1, 1'b0, 0, bc, dn);
        ref_step(8'h5A, aliveColor);
        check("wrap639_cell638", mem[638], 4'b0101);
        check("wrap639_cell0", mem[0], 4'b0101);
        check("wrap639_cell639", mem[639], 4'b0000);
        check("wrap_generation", generation, 3);

        // random images and rules, with and without display stalls
        for (int t = 0; t < 3; t++) begin
            rule = 8'($urandom);
            aliveColor = 3'($urandom_range(1, 7));
            load_image(0, 0);
            run_pass(1'b1, (t != 1), 0, bc, dn);
            ref_step(rule, aliveColor);
            compare_mem("random_mem");
            check("random_done_pulses", dn, 1);
            if (t == 1) check("random_pass_cycles", bc, 1282);
        end
        check("we_during_display", we_viol, 0);
        check("random_generation", generation, 6);

        // two requests while busy collapse into exactly one further pass
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_clears_generation", generation, 0);
        rule = 8'h1E;
        aliveColor = 3'b110;
        load_image(0, 0);
        run_pass(1'b1, 1'b0, 2, bc, dn);
        ref_step(rule, aliveColor);
        run_pass(1'b0, 1'b0, 0, bc, dn);
        ref_step(rule, aliveColor);
        compare_mem("pending_mem");
        check("pending_generation", generation, 2);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tick();
        check("no_third_pass", busy, 0);

        // reset while cell 300 is about to be written
        rule = 8'h5A;
        load_image(0, 0);
        for (int k = 0; k < CELLS; k++) old[k] = expv[k];
        ref_step(rule, aliveColor);
        for (int k = 300; k < CELLS; k++) expv[k] = old[k];
        stepRequest = 1'b1;
        tick();
        stepRequest = 1'b0;
        tick();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        bc = 0;
        while (bc < 3000 && !(memWe && memAddr == 10'd300)) begin
            tick();
            bc++;
        end
        check("reached_cell300", (bc < 3000) ? 1 : 0, 1);
        rst = 1'b1;
        #1;
        check("abort_memWe", memWe, 0);
        check("abort_memAddr", memAddr, 0);
        check("abort_memWdata", memWdata, 0);
        check("abort_busy", busy, 0);
        check("abort_generation", generation, 0);
        extra_done = 0;
        repeat (2) begin
            tick();
            if (stepDone) extra_done++;
        end
        rst = 1'b0;
        repeat (5) begin
            tick();
            if (stepDone) extra_done++;
        end
        check("abort_no_stepDone", extra_done, 0);
        compare_mem("abort_mem");
        check("final_we_during_display", we_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
